// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types, constants and sizing helpers for the serial adder. Rev 1.0
`default_nettype none

package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int ncyc(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic int cnt_w(input int width, input int digit);
      return (width / digit > 1) ? $clog2(width / digit) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_add_digit.sv
// serial_add_digit: DIGIT-bit ripple adder slice, also exposing the carry into its top bit. Rev 1.0
`default_nettype none

module serial_add_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             c_msb_in
);

   logic [DIGIT:0] c;

   always_comb begin
      s    = '0;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < DIGIT; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout     = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/serial_add_unit.sv
// serial_add_unit: LSB-first digit-serial add/sub with accumulator, carry/overflow/zero flags. Rev 1.0
`default_nettype none

module serial_add_unit
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_sub,
   input  logic             acc_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int NCYC = ncyc(WIDTH, DIGIT);
   localparam int CW   = cnt_w(WIDTH, DIGIT);
   localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

   if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_add_unit: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res, res_next;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             last;
   logic [DIGIT-1:0] dsum;
   logic             dcout, dc_msb_in;

   serial_add_digit #(.DIGIT(DIGIT)) u_digit (
      .a        (a_sh[DIGIT-1:0]),
      .b        (b_sh[DIGIT-1:0]),
      .cin      (carry),
      .s        (dsum),
      .cout     (dcout),
      .c_msb_in (dc_msb_in)
   );

   // New sum digits enter the result register from the MSB end.
   if (NCYC > 1) begin : g_multi
      assign res_next = {dsum, res[WIDTH-1:DIGIT]};
   end else begin : g_single
      assign res_next = dsum;
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign last      = (state == RUN) && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh      <= '0;
         b_sh      <= '0;
         res       <= '0;
         cnt       <= '0;
         carry     <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else if (state == IDLE) begin
         if (in_valid) begin
            a_sh  <= acc_en ? res : op_a;
            b_sh  <= (op_sub == OP_SUB) ? ~op_b : op_b;
            carry <= op_sub;
            cnt   <= '0;
         end
      end else if (state == RUN) begin
         a_sh  <= a_sh >> DIGIT;
         b_sh  <= b_sh >> DIGIT;
         res   <= res_next;
         carry <= dcout;
         cnt   <= cnt + 1'b1;
         // Outputs move only once the full result is assembled.
         if (last) begin
            sum       <= res_next;
            carry_out <= dcout;
            overflow  <= dcout ^ dc_msb_in;
            zero      <= (res_next == '0);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_unit.sv
// tb_serial_add_unit: directed checks of the 8/1 and 16/4 serial adders plus a randomized 16/4 run. Rev 1.0
`default_nettype none

module tb_serial_add_unit;

   logic        clk, rst_n;
   logic        in_valid8, in_ready8, op_sub8, acc_en8, out_valid8, out_ready8;
   logic        carry8, ovf8, zero8;
   logic [7:0]  op_a8, op_b8, sum8;
   logic        in_valid16, in_ready16, op_sub16, acc_en16, out_valid16, out_ready16;
   logic        carry16, ovf16, zero16;
   logic [15:0] op_a16, op_b16, sum16;

   int tests = 0;
   int fails = 0;

   serial_add_unit #(.WIDTH(8), .DIGIT(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .op_a(op_a8), .op_b(op_b8), .op_sub(op_sub8), .acc_en(acc_en8),
      .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
      .carry_out(carry8), .overflow(ovf8), .zero(zero8)
   );

   serial_add_unit #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .op_a(op_a16), .op_b(op_b16), .op_sub(op_sub16), .acc_en(acc_en16),
      .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16),
      .carry_out(carry16), .overflow(ovf16), .zero(zero16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic acc);
      @(negedge clk);
      op_a8 = a; op_b8 = b; op_sub8 = sub; acc_en8 = acc; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
   endtask

   task automatic wait8(output int lat);
      lat = 0;
      while (!out_valid8 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic ack8();
      @(negedge clk);
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
   endtask

   task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic acc);
      @(negedge clk);
      op_a16 = a; op_b16 = b; op_sub16 = sub; acc_en16 = acc; in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
   endtask

   task automatic wait16(output int lat);
      lat = 0;
      while (!out_valid16 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic ack16();
      @(negedge clk);
      out_ready16 = 1'b1;
      @(posedge clk); #1;
      out_ready16 = 1'b0;
   endtask

   task automatic test_reset();
      logic [12:0] got, exp;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      got = {in_ready8, out_valid8, sum8, carry8, ovf8, zero8};
      exp = {1'b1, 1'b0, 8'h00, 3'b000};
      tests++;
      if (got !== exp) begin
         fails++; $display("FAIL reset_w8: got %h expected %h", got, exp);
      end
      tests++;
      if ({in_ready16, out_valid16, sum16, carry16, ovf16, zero16} !== {2'b10, 16'h0000, 3'b000}) begin
         fails++;
         $display("FAIL reset_w16: got %h expected %h",
                  {in_ready16, out_valid16, sum16, carry16, ovf16, zero16}, {2'b10, 16'h0000, 3'b000});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      int lat;
      start8(8'h7F, 8'h01, 1'b0, 1'b0);
      wait8(lat);
      tests++;
      if (lat !== 8) begin
         fails++; $display("FAIL add_latency: got %0d expected %0d", lat, 8);
      end
      tests++;
      if ({sum8, carry8, ovf8, zero8} !== {8'h80, 3'b010}) begin
         fails++; $display("FAIL add_7f_01: got %h expected %h", {sum8, carry8, ovf8, zero8}, {8'h80, 3'b010});
      end
      ack8();
   endtask

   task automatic test_sub();
      int lat;
      start8(8'h05, 8'h05, 1'b1, 1'b0);
      wait8(lat);
      tests++;
      if ({sum8, carry8, ovf8, zero8} !== {8'h00, 3'b101}) begin
         fails++; $display("FAIL sub_5_5: got %h expected %h", {sum8, carry8, ovf8, zero8}, {8'h00, 3'b101});
      end
      ack8();
      start8(8'h03, 8'h05, 1'b1, 1'b0);
      wait8(lat);
      tests++;
      if ({sum8, carry8, ovf8, zero8} !== {8'hFE, 3'b000}) begin
         fails++; $display("FAIL sub_3_5: got %h expected %h", {sum8, carry8, ovf8, zero8}, {8'hFE, 3'b000});
      end
      ack8();
   endtask

   task automatic test_accumulate();
      int lat;
      start8(8'h10, 8'h00, 1'b0, 1'b0);
      wait8(lat);
      ack8();
      start8(8'hAA, 8'h20, 1'b0, 1'b1);
      wait8(lat);
      tests++;
      if ({sum8, carry8, ovf8, zero8} !== {8'h30, 3'b000}) begin
         fails++; $display("FAIL acc_plus_20: got %h expected %h", {sum8, carry8, ovf8, zero8}, {8'h30, 3'b000});
      end
      ack8();
      start8(8'h55, 8'hE0, 1'b0, 1'b1);
      wait8(lat);
      tests++;
      if ({sum8, carry8, ovf8, zero8} !== {8'h10, 3'b100}) begin
         fails++; $display("FAIL acc_plus_e0: got %h expected %h", {sum8, carry8, ovf8, zero8}, {8'h10, 3'b100});
      end
      ack8();
   endtask

   task automatic test_backpressure();
      int lat;
      start8(8'h44, 8'h11, 1'b0, 1'b0);
      wait8(lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         op_a8 = 8'h01; op_b8 = 8'h01; op_sub8 = 1'b0; acc_en8 = 1'b0; in_valid8 = 1'b1;
         @(posedge clk); #1;
         tests++;
         if ({out_valid8, in_ready8, sum8, carry8, ovf8, zero8} !== {2'b10, 8'h55, 3'b000}) begin
            fails++;
            $display("FAIL backpressure_hold cycle %0d: got %h expected %h", i,
                     {out_valid8, in_ready8, sum8, carry8, ovf8, zero8}, {2'b10, 8'h55, 3'b000});
         end
      end
      in_valid8 = 1'b0;
      ack8();
      tests++;
      if ({out_valid8, in_ready8, sum8} !== {2'b01, 8'h55}) begin
         fails++; $display("FAIL after_release: got %h expected %h", {out_valid8, in_ready8, sum8}, {2'b01, 8'h55});
      end
      start8(8'h00, 8'h00, 1'b0, 1'b1);
      wait8(lat);
      tests++;
      if (sum8 !== 8'h55) begin
         fails++; $display("FAIL acc_untouched: got %h expected %h", sum8, 8'h55);
      end
      ack8();
   endtask

   task automatic test_reset_mid_run();
      int lat;
      start8(8'h11, 8'h22, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({in_ready8, out_valid8, sum8, carry8, ovf8, zero8} !== {2'b10, 8'h00, 3'b000}) begin
         fails++;
         $display("FAIL async_reset: got %h expected %h",
                  {in_ready8, out_valid8, sum8, carry8, ovf8, zero8}, {2'b10, 8'h00, 3'b000});
      end
      @(negedge clk);
      rst_n = 1'b1;
      start8(8'h99, 8'h05, 1'b0, 1'b1);
      wait8(lat);
      tests++;
      if (sum8 !== 8'h05) begin
         fails++; $display("FAIL acc_cleared: got %h expected %h", sum8, 8'h05);
      end
      ack8();
      start8(8'h01, 8'h01, 1'b0, 1'b0);
      wait8(lat);
      tests++;
      if ({sum8, carry8, ovf8, zero8} !== {8'h02, 3'b000}) begin
         fails++; $display("FAIL post_reset_add: got %h expected %h", {sum8, carry8, ovf8, zero8}, {8'h02, 3'b000});
      end
      ack8();
   endtask

   task automatic test_w16();
      int          lat;
      logic [15:0] macc, a, b, bb, res;
      logic        sub, acc, c, v, z, cmsb;
      logic [16:0] full;
      logic [15:0] low;
      start16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait16(lat);
      tests++;
      if (lat !== 4) begin
         fails++; $display("FAIL w16_latency: got %0d expected %0d", lat, 4);
      end
      tests++;
      if ({sum16, carry16, ovf16, zero16} !== {16'h0000, 3'b101}) begin
         fails++; $display("FAIL w16_ffff_1: got %h expected %h", {sum16, carry16, ovf16, zero16}, {16'h0000, 3'b101});
      end
      ack16();
      macc = 16'h0000;
      for (int n = 0; n < 1000; n++) begin
         a    = 16'($urandom);
         b    = 16'($urandom);
         sub  = 1'($urandom_range(0, 1));
         acc  = ($urandom_range(0, 3) == 0);
         if (acc) a = macc;
         bb   = sub ? ~b : b;
         full = {1'b0, a} + {1'b0, bb} + {16'h0000, sub};
         res  = full[15:0];
         c    = full[16];
         low  = {1'b0, a[14:0]} + {1'b0, bb[14:0]} + {15'h0000, sub};
         cmsb = low[15];
         v    = c ^ cmsb;
         z    = (res == 16'h0000);
         macc = res;
         start16(acc ? 16'hDEAD : a, b, sub, acc);
         wait16(lat);
         tests++;
         if (lat !== 4 || {sum16, carry16, ovf16, zero16} !== {res, c, v, z}) begin
            fails++;
            $display("FAIL w16_random op %0d: got lat %0d %h expected lat 4 %h", n, lat,
                     {sum16, carry16, ovf16, zero16}, {res, c, v, z});
         end
         ack16();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; op_a8 = '0; op_b8 = '0; op_sub8 = 1'b0; acc_en8 = 1'b0;
      in_valid16 = 1'b0; out_ready16 = 1'b0; op_a16 = '0; op_b16 = '0; op_sub16 = 1'b0; acc_en16 = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_accumulate();
      test_backpressure();
      test_reset_mid_run();
      test_w16();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
